// File: rtl/spi_byte_port.sv
// SPI mode-0 peripheral front end: oversamples raw SPI pins in the pixel-clock
// domain and converts them into byte-wide receive/transmit strobes.
module spi_byte_port #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_CIPO   = 1'b1
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       spi_sck_i,
    input  logic       spi_copi_i,
    output logic       spi_cipo_o,
    input  logic       spi_cs_i,
    output logic       select_o,
    output logic       receive_strobe_o,
    output logic [7:0] receive_byte_o,
    output logic       transmit_strobe_o,
    input  logic [7:0] transmit_byte_i
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_d;
    logic                   cs_d;

    logic       sck_s;
    logic       copi_s;
    logic       cs_s;
    logic       selected;
    logic       sck_rise;
    logic       sck_fall;
    logic       cs_fall;
    logic       byte_done;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] receive_byte;
    logic       rx_strobe;
    logic       tx_strobe;

    // Input synchronizers; presets match an idle bus (SCK low, CS deasserted).
    always_ff @(posedge clk) begin
        if (reset_i) begin
            sck_sync  <= '0;
            copi_sync <= '0;
            cs_sync   <= '1;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi_copi_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign selected  = ~cs_s;
    // A CS rise deselects in the same cycle, so a coincident 8th SCK rise is dropped.
    assign sck_rise  = selected & sck_s & ~sck_d;
    assign sck_fall  = selected & ~sck_s & sck_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign byte_done = sck_rise && (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            bit_cnt      <= 3'd0;
            rx_shift     <= 8'h00;
            tx_shift     <= 8'h00;
            receive_byte <= 8'h00;
            rx_strobe    <= 1'b0;
            tx_strobe    <= 1'b0;
        end else begin
            rx_strobe <= byte_done;
            tx_strobe <= cs_fall | byte_done;

            if (!selected || cs_fall) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (sck_rise) begin
                rx_shift <= {rx_shift[6:0], copi_s};
            end
            if (byte_done) begin
                receive_byte <= {rx_shift[6:0], copi_s};
            end

            // The fall right after a byte boundary must keep the freshly loaded MSB.
            if (tx_strobe) begin
                tx_shift <= transmit_byte_i;
            end else if (sck_fall && (bit_cnt != 3'd0)) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    assign select_o          = selected;
    assign receive_strobe_o  = rx_strobe & selected;
    assign transmit_strobe_o = tx_strobe & selected;
    assign receive_byte_o    = receive_byte;
    assign spi_cipo_o        = selected ? tx_shift[7] : IDLE_CIPO;

endmodule

// File: doc/spi_byte_port.md
Name: spi_byte_port

Overview:
- SPI mode-0 peripheral front end (FPGA is the target) that turns raw SPI pins into byte-level strobes for the SPI-to-bus command decoder.
- Oversamples asynchronous SCK/COPI/CS_N in the pixel-clock domain and shifts bytes in and out MSB-first.
- Emits a receive strobe per completed byte and a transmit strobe requesting the next outgoing byte.
- Sits between the FTDI/SPI pins and the command/payload logic that drives the Xosera bus signals.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2).
IDLE_CIPO, 1'b1, level driven on spi_cipo_o while deselected or in reset.

Ports:
clk  input  1  pixel clock; all logic on posedge.
reset_i  input  1  synchronous, active-high reset.
spi_sck_i  input  1  SPI clock from controller, asynchronous.
spi_copi_i  input  1  controller-out/peripheral-in data, asynchronous.
spi_cipo_o  output  1  controller-in/peripheral-out data.
spi_cs_i  input  1  chip select from controller, active LOW, asynchronous.
select_o  output  1  synchronized select, active HIGH.
receive_strobe_o  output  1  one-cycle pulse: receive_byte_o holds a new byte.
receive_byte_o  output  8  last completed received byte.
transmit_strobe_o  output  1  one-cycle pulse: transmit_byte_i is sampled at the end of this cycle.
transmit_byte_i  input  8  next byte to shift out.

Behaviour:
- Reset (reset_i high at posedge):
  - select_o=0, receive_strobe_o=0, transmit_strobe_o=0, receive_byte_o=8'h00, spi_cipo_o=IDLE_CIPO.
  - bit_cnt=0, shift registers cleared.
  - Synchronizer chains preset to idle: SCK=0, CS=1.
  - Reset overrides any transfer in progress; the partial byte is discarded with no strobes.
- Synchronization and edge detection:
  - Each input passes SYNC_STAGES FFs; a further delayed copy of SCK and CS gives the edges.
  - Edges: sck_rise, sck_fall, cs_fall, cs_rise.
  - Pin-to-action latency is SYNC_STAGES+1 clk cycles.
  - Controller constraint: SCK high and low phases each at least SYNC_STAGES+2 clk periods.
- select_o equals the synchronized, inverted CS.
- When select_o=0, SCK edges are ignored, bit_cnt is held at 0 and spi_cipo_o=IDLE_CIPO.
- cs_fall:
  - bit_cnt<=0; transmit_strobe_o pulses the next cycle (cycle T).
  - transmit_byte_i is loaded into tx_shift at the end of T.
  - spi_cipo_o=tx_shift[7] from T+1.
- sck_rise while selected:
  - rx_shift<={rx_shift[6:0], copi_sync}; bit_cnt<=bit_cnt+1 (3-bit, wraps 7->0).
- On the rise that wraps bit_cnt to 0 (8th bit):
  - Next cycle: receive_strobe_o=1 and receive_byte_o=completed byte.
  - receive_byte_o holds until the next strobe.
  - transmit_strobe_o pulses in that same cycle; tx_shift reloads at the end of it.
- sck_fall while selected:
  - If bit_cnt!=0: tx_shift<={tx_shift[6:0],1'b0}.
  - If bit_cnt==0: no shift, so the freshly loaded MSB is preserved.
  - spi_cipo_o is always tx_shift[7] while selected.
- cs_rise:
  - select_o drops; the partial byte is discarded (no receive_strobe_o); bit_cnt<=0.
  - If the 8th sck_rise and cs_rise are detected in the same cycle, the byte is discarded.
- Strobes are single-cycle and never asserted while select_o=0.
- Back-to-back bytes within one CS need no gap beyond the SCK timing constraint.

Test Plan:
- Reset: hold reset_i 3 cycles, toggle pins -> all outputs at reset values, no strobes, spi_cipo_o=1.
- Single byte: transmit_byte_i=8'h3C, CS low, clock in 0xA5 -> transmit_strobe_o 1 pulse after cs_fall; CIPO bits 0,0,1,1,1,1,0,0 sampled on rises; receive_strobe_o 1 pulse, receive_byte_o=8'hA5, second transmit_strobe_o in same cycle.
- Two-byte packet: send 0xC3 then 0x55 in one CS, transmit_byte_i=8'hCB then 8'h7E -> receive strobes with 0xC3 then 0x55; CIPO returns 0xCB then 0x7E; 3 transmit strobes total.
- Abort: CS high after 5 bits, then new CS with 0x81 -> no strobe for the partial byte; next receive_byte_o=8'h81 (alignment restored).
- Deselected noise: 20 SCK toggles with CS high -> no strobes, bit_cnt stays 0, select_o=0, CIPO=IDLE_CIPO.
- Reset mid-transfer after 4 bits, then release and send 0x5A -> no strobe from the partial byte; 0x5A received correctly.
